// File: rtl/apb_pkg.sv
// Shared APB definitions: transfer states, address field positions and the
// default error read-data pattern also used by the slave wrappers.
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  localparam int APB_ADDR_HI = 19;
  localparam int APB_ADDR_LO = 2;
  localparam int SLV_IDX_HI  = 23;
  localparam int SLV_IDX_LO  = 20;

  localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEADBEEF;

endpackage

// File: rtl/apb_psel_decoder.sv
// Slave index to one-hot PSEL decode; flags indices beyond the populated slaves.
module apb_psel_decoder #(
  parameter int NUM_SLAVES = 16
) (
  input  logic [3:0]            idx,
  output logic [NUM_SLAVES-1:0] sel,
  output logic                  invalid
);

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      sel[i] = (32'(idx) == i);
    end
    invalid = (32'(idx) >= NUM_SLAVES);
  end

endmodule

// File: rtl/apb_master_bridge.sv
// Valid/ready request to APB3 initiator with slave decode, PREADY timeout and
// a registered valid/ready response port.
//
// state  | meaning
// IDLE   | waiting for a request; req_ready high
// SETUP  | PSEL driven, PENABLE low, exactly one cycle
// ACCESS | PENABLE high, waiting for PREADY or timeout
// RESP   | rsp_valid high until rsp_ready
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int          NUM_SLAVES     = 16,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [23:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic [NUM_SLAVES-1:0] PSEL,
  output logic [17:0]           PADDR,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [31:0]           PWDATA,
  input  logic [31:0]           PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  apb_state_e            state_q, state_d;
  logic [NUM_SLAVES-1:0] psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [17:0]           paddr_q, paddr_d;
  logic [31:0]           pwdata_q, pwdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;
  logic [7:0]            cnt_q, cnt_d;

  logic [NUM_SLAVES-1:0] dec_sel;
  logic                  dec_invalid;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^req_addr[1:0];

  apb_psel_decoder #(.NUM_SLAVES(NUM_SLAVES)) u_dec (
    .idx     (req_addr[SLV_IDX_HI:SLV_IDX_LO]),
    .sel     (dec_sel),
    .invalid (dec_invalid)
  );

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (dec_invalid) begin
            // No bus cycle for an unmapped slave; answer straight away.
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = ERR_RDATA;
            state_d     = ST_RESP;
          end else begin
            psel_d    = dec_sel;
            penable_d = 1'b0;
            pwrite_d  = req_write;
            paddr_d   = req_addr[APB_ADDR_HI:APB_ADDR_LO];
            pwdata_d  = req_wdata;
            state_d   = ST_SETUP;
          end
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (PREADY) begin
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = PSLVERR;
          rsp_rdata_d = pwrite_q ? 32'h0 : PRDATA;
          state_d     = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          psel_d      = '0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = ERR_RDATA;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= ST_IDLE;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      cnt_q       <= cnt_d;
    end
  end

  assign req_ready = (state_q == ST_IDLE) & ~PRESET;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge with 8 slaves and a 4-cycle PREADY timeout:
// directed vector table, hand-written multi-cycle sequences, random traffic.
module tb_apb_master_bridge;

  localparam int NSLV = 8;
  localparam int TMO  = 4;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        req_valid, req_ready, req_write;
  logic [23:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [NSLV-1:0] PSEL;
  logic [17:0] PADDR;
  logic        PENABLE, PWRITE;
  logic [31:0] PWDATA, PRDATA;
  logic        PREADY, PSLVERR;

  apb_master_bridge #(.NUM_SLAVES(NSLV), .TIMEOUT_CYCLES(TMO), .ERR_RDATA(32'hDEADBEEF)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PADDR(PADDR), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic        wr;
    logic [23:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic        slverr;
    logic [31:0] prdata;
    int          hold;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
    logic [7:0]  exp_psel;
  } vec_t;

  int total = 0;
  int bad   = 0;
  logic [17:0] last_paddr;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // Transaction-level expectation from the bridge's rules.
  function automatic vec_t model(vec_t v);
    vec_t r = v;
    int idx = int'(v.addr[23:20]);
    if (idx >= NSLV) begin
      r.exp_psel = 8'h00; r.exp_err = 1'b1; r.exp_rdata = 32'hDEADBEEF; r.exp_lat = 1;
    end else begin
      r.exp_psel = 8'(1 << idx);
      if (v.waits >= TMO) begin
        r.exp_err = 1'b1; r.exp_rdata = 32'hDEADBEEF; r.exp_lat = 2 + TMO;
      end else begin
        r.exp_err = v.slverr; r.exp_rdata = v.wr ? 32'h0 : v.prdata; r.exp_lat = 3 + v.waits;
      end
    end
    return r;
  endfunction

  task automatic do_txn(input vec_t v);
    int cyc = 1;
    int acc = 0;
    bit done = 0;
    bit seen_sel = 0;
    req_valid = 1'b1; req_write = v.wr; req_addr = v.addr; req_wdata = v.wdata;
    PRDATA = v.prdata; PSLVERR = v.slverr; PREADY = 1'b0; rsp_ready = 1'b0;
    chk("req_ready_idle", req_ready, 1);
    tick();
    req_valid = 1'b0; req_write = 1'($urandom); req_addr = 24'($urandom); req_wdata = $urandom;
    while (!done && cyc <= 20) begin
      if (rsp_valid) begin
        done = 1;
      end else begin
        chk("req_ready_busy", req_ready, 0);
        chk("psel", PSEL, v.exp_psel);
        PREADY = 1'b0;
        if (PSEL != 0) begin
          chk("paddr", PADDR, v.addr[19:2]);
          chk("pwrite", PWRITE, v.wr);
          chk("pwdata", PWDATA, v.wdata);
          chk(seen_sel ? "penable_access" : "penable_setup", PENABLE, seen_sel);
          seen_sel = 1;
          if (PENABLE) begin
            PREADY = (acc == v.waits);
            acc++;
          end
        end
        tick();
        cyc++;
      end
    end
    PREADY = 1'b0;
    if (!done) $display("FAIL rsp_timeout: no rsp_valid within %0d cycles (addr %0h)", 20, v.addr);
    chk("rsp_seen", done, 1);
    chk("rsp_latency", cyc, v.exp_lat);
    chk("rsp_err", rsp_err, v.exp_err);
    chk("rsp_rdata", rsp_rdata, v.exp_rdata);
    chk("psel_resp", PSEL, 0);
    chk("penable_resp", PENABLE, 0);
    chk("access_cycles", acc, (v.exp_psel == 0) ? 0 : v.exp_lat - 2);
    if (v.exp_psel != 0) last_paddr = v.addr[19:2];
    for (int h = 0; h < v.hold; h++) begin
      req_valid = 1'b1; req_addr = 24'h100000; req_write = 1'b0;
      tick();
      chk("hold_valid", rsp_valid, 1);
      chk("hold_err", rsp_err, v.exp_err);
      chk("hold_rdata", rsp_rdata, v.exp_rdata);
      chk("hold_req_ready", req_ready, 0);
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_cleared", rsp_valid, 0);
    chk("req_ready_back", req_ready, 1);
    chk("psel_after", PSEL, 0);
    chk("paddr_kept", PADDR, last_paddr);
  endtask

  vec_t dir_tab[7];

  initial begin
    dir_tab[0] = '{1'b1, 24'h100004, 32'h000000FF, 0, 1'b0, 32'h55555555, 0, 1'b0, 32'h0,        3, 8'h02};
    dir_tab[1] = '{1'b0, 24'h000008, 32'h0,        3, 1'b0, 32'h12345678, 0, 1'b0, 32'h12345678, 6, 8'h01};
    dir_tab[2] = '{1'b0, 24'h200010, 32'h0,        9, 1'b0, 32'h11112222, 0, 1'b1, 32'hDEADBEEF, 6, 8'h04};
    dir_tab[3] = '{1'b0, 24'h300000, 32'h0,        0, 1'b1, 32'hCAFEF00D, 0, 1'b1, 32'hCAFEF00D, 3, 8'h08};
    dir_tab[4] = '{1'b1, 24'hA00000, 32'h77,       0, 1'b0, 32'h0,        0, 1'b1, 32'hDEADBEEF, 1, 8'h00};
    dir_tab[5] = '{1'b0, 24'h7FFFFC, 32'h0,        1, 1'b0, 32'hA5A5A5A5, 5, 1'b0, 32'hA5A5A5A5, 4, 8'h80};
    dir_tab[6] = '{1'b1, 24'h500040, 32'h9,        2, 1'b1, 32'h33333333, 1, 1'b1, 32'h0,        5, 8'h20};

    PRESET = 1'b1; req_valid = 1'b1; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    tick();
    tick();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_pwrite", PWRITE, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwdata", PWDATA, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    req_valid = 1'b0; PRESET = 1'b0;
    #1;
    chk("rst_release_ready", req_ready, 1);
    last_paddr = '0;

    foreach (dir_tab[i]) do_txn(dir_tab[i]);

    // Back-to-back: handshake every 4 cycles, response one cycle before each.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 24'h000000; rsp_ready = 1'b1;
    PREADY = 1'b1; PSLVERR = 1'b0; PRDATA = 32'h0BADF00D;
    for (int c = 0; c < 12; c++) begin
      chk("b2b_req_ready", req_ready, (c % 4) == 0);
      chk("b2b_rsp_valid", rsp_valid, (c % 4) == 3);
      if ((c % 4) == 3) chk("b2b_rdata", rsp_rdata, 32'h0BADF00D);
      tick();
    end
    req_valid = 1'b0; PREADY = 1'b0; rsp_ready = 1'b0;
    last_paddr = 18'h0;
    chk("b2b_idle", req_ready, 1);

    // Reset asserted during ACCESS abandons the transfer silently.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 24'h400020; req_wdata = 32'h12;
    tick();
    req_valid = 1'b0;
    tick();
    chk("mid_access_penable", PENABLE, 1);
    PRESET = 1'b1;
    #1;
    chk("mid_rst_req_ready", req_ready, 0);
    tick();
    PRESET = 1'b0;
    chk("mid_rst_psel", PSEL, 0);
    chk("mid_rst_penable", PENABLE, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    #1;
    chk("mid_rst_req_ready_after", req_ready, 1);
    rsp_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("mid_rst_no_rsp", rsp_valid, 0);
    end
    rsp_ready = 1'b0;
    last_paddr = '0;

    for (int n = 0; n < 40; n++) begin
      vec_t v;
      v.wr     = 1'($urandom);
      v.addr   = {4'($urandom_range(0, 9)), 20'($urandom)};
      v.wdata  = $urandom;
      v.waits  = $urandom_range(0, 5);
      v.slverr = 1'($urandom);
      v.prdata = $urandom;
      v.hold   = $urandom_range(0, 2);
      do_txn(model(v));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

endmodule
